// File: rtl/prog_counter_n_if.sv
// Control and observation bundle for prog_counter_n.
// The master drives the controls; the slave (the counter) drives the status outputs.
interface prog_counter_n_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) ();
  logic              en;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              limit_we;
  logic [WIDTH-1:0]  limit_val;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic              oe;
  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  q_out;
  logic              q_oe;
  logic              tc;
  logic              halted;

  modport master (
    output en, clr, load, load_val, limit_we, limit_val, dir, step, mode, oe,
    input  count, q_out, q_oe, tc, halted
  );

  modport slave (
    input  en, clr, load, load_val, limit_we, limit_val, dir, step, mode, oe,
    output count, q_out, q_oe, tc, halted
  );
endinterface

// File: rtl/prog_counter_n.sv
// Programmable up/down counter with a variable step, a programmable limit, and wrap,
// saturate or one-shot behaviour at the boundary.
module prog_counter_n #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  prog_counter_n_if.slave bus
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_tc;
  logic             r_halted;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_sum;
  logic             w_cross;
  logic [WIDTH-1:0] w_count_d;
  logic             w_tc_d;
  logic             w_halted_d;

  assign w_step = WIDTH'(bus.step);
  // One extra bit so count+step never overflows before the limit comparison.
  assign w_sum  = {1'b0, r_count} + {1'b0, w_step};

  // A zero step can never cross, even if count already sits above a lowered limit.
  assign w_cross = (w_step != '0) &
                   (bus.dir ? (w_sum > {1'b0, r_limit}) : (r_count < w_step));

  always_comb begin
    w_count_d  = r_count;
    w_tc_d     = 1'b0;
    w_halted_d = r_halted;
    if (bus.clr) begin
      w_count_d  = '0;
      w_halted_d = 1'b0;
    end else if (bus.load) begin
      w_count_d  = bus.load_val;
      w_halted_d = 1'b0;
    end else if (bus.en && !r_halted) begin
      if (!w_cross) begin
        w_count_d = bus.dir ? w_sum[WIDTH-1:0] : (r_count - w_step);
      end else begin
        w_tc_d = 1'b1;
        case (bus.mode)
          MODE_SAT: begin
            w_count_d = bus.dir ? r_limit : '0;
          end
          MODE_ONESHOT: begin
            w_count_d  = bus.dir ? r_limit : '0;
            w_halted_d = 1'b1;
          end
          default: begin
            w_count_d = bus.dir ? '0 : r_limit;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_limit  <= '1;
      r_tc     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_count  <= w_count_d;
      r_tc     <= w_tc_d;
      r_halted <= w_halted_d;
      if (bus.limit_we) begin
        r_limit <= bus.limit_val;
      end
    end
  end

  assign bus.count  = r_count;
  assign bus.q_out  = bus.oe ? r_count : '0;
  assign bus.q_oe   = bus.oe;
  assign bus.tc     = r_tc;
  assign bus.halted = r_halted;

endmodule

// File: tb/tb_prog_counter_n.sv
// Directed and randomized checks of prog_counter_n against an integer reference model.
module tb_prog_counter_n;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  int m_count;
  int m_limit;
  int m_tc;
  int m_halted;

  int exp41_cnt[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp42_cnt[4]  = '{4, 1, 0, 0};
  int exp42_tc[4]   = '{0, 0, 1, 1};
  int exp43_cnt[3]  = '{2, 4, 5};

  prog_counter_n_if #(.WIDTH(8), .STEP_W(4)) bus_if ();

  prog_counter_n #(
    .WIDTH (8),
    .STEP_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_limit  = 255;
    m_tc     = 0;
    m_halted = 0;
  endtask

  // Behaviour of one rising edge, from the current inputs and model state.
  task automatic model_edge();
    int nc;
    int nh;
    int nt;
    int st;
    bit crossing;
    nc = m_count;
    nh = m_halted;
    nt = 0;
    st = int'(bus_if.step);
    if (bus_if.clr) begin
      nc = 0;
      nh = 0;
    end else if (bus_if.load) begin
      nc = int'(bus_if.load_val);
      nh = 0;
    end else if (bus_if.en && m_halted == 0 && st != 0) begin
      crossing = bus_if.dir ? (m_count + st > m_limit) : (m_count < st);
      if (!crossing) begin
        nc = bus_if.dir ? m_count + st : m_count - st;
      end else begin
        nt = 1;
        case (bus_if.mode)
          2'b01: nc = bus_if.dir ? m_limit : 0;
          2'b10: begin
            nc = bus_if.dir ? m_limit : 0;
            nh = 1;
          end
          default: nc = bus_if.dir ? 0 : m_limit;
        endcase
      end
    end
    if (bus_if.limit_we) m_limit = int'(bus_if.limit_val);
    m_count  = nc;
    m_halted = nh;
    m_tc     = nt;
  endtask

  task automatic check_all();
    chk("count", 32'(bus_if.count), m_count);
    chk("tc", 32'(bus_if.tc), m_tc);
    chk("halted", 32'(bus_if.halted), m_halted);
    chk("q_out", 32'(bus_if.q_out), bus_if.oe ? m_count : 0);
    chk("q_oe", 32'(bus_if.q_oe), 32'(bus_if.oe));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus_if.en        = 1'b0;
    bus_if.clr       = 1'b0;
    bus_if.load      = 1'b0;
    bus_if.load_val  = 8'h00;
    bus_if.limit_we  = 1'b0;
    bus_if.limit_val = 8'h00;
    bus_if.dir       = 1'b1;
    bus_if.step      = 4'd1;
    bus_if.mode      = 2'b00;
    bus_if.oe        = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Wrap, limit 9, step 1 up.
    bus_if.clr = 1'b1; bus_if.limit_we = 1'b1; bus_if.limit_val = 8'd9;
    cyc();
    bus_if.clr = 1'b0; bus_if.limit_we = 1'b0; bus_if.en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk("wrap_cnt", 32'(bus_if.count), exp41_cnt[i]);
      chk("wrap_tc", 32'(bus_if.tc), (i == 9) ? 1 : 0);
    end

    // Saturate down, step 3 from 7.
    bus_if.en = 1'b0; bus_if.load = 1'b1; bus_if.load_val = 8'd7;
    bus_if.mode = 2'b01; bus_if.dir = 1'b0; bus_if.step = 4'd3;
    cyc();
    bus_if.load = 1'b0; bus_if.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_cnt", 32'(bus_if.count), exp42_cnt[i]);
      chk("sat_tc", 32'(bus_if.tc), exp42_tc[i]);
    end

    // One-shot up, limit 5, step 2.
    bus_if.en = 1'b0; bus_if.clr = 1'b1; bus_if.limit_we = 1'b1; bus_if.limit_val = 8'd5;
    cyc();
    bus_if.clr = 1'b0; bus_if.limit_we = 1'b0; bus_if.en = 1'b1;
    bus_if.mode = 2'b10; bus_if.dir = 1'b1; bus_if.step = 4'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("os_cnt", 32'(bus_if.count), exp43_cnt[i]);
    end
    chk("os_halt", 32'(bus_if.halted), 1);
    chk("os_tc", 32'(bus_if.tc), 1);
    repeat (2) cyc();
    chk("os_hold_cnt", 32'(bus_if.count), 5);
    chk("os_hold_tc", 32'(bus_if.tc), 0);
    bus_if.en = 1'b0; bus_if.load = 1'b1; bus_if.load_val = 8'h01;
    cyc();
    chk("os_load_cnt", 32'(bus_if.count), 1);
    chk("os_load_halt", 32'(bus_if.halted), 0);

    // Priority clr > load > en.
    bus_if.clr = 1'b1; bus_if.load = 1'b1; bus_if.en = 1'b1; bus_if.load_val = 8'h80;
    cyc();
    chk("prio_clr", 32'(bus_if.count), 0);
    bus_if.clr = 1'b0;
    cyc();
    chk("prio_load", 32'(bus_if.count), 8'h80);

    // Output enable never affects counting.
    bus_if.load = 1'b0; bus_if.en = 1'b0; bus_if.clr = 1'b1;
    bus_if.limit_we = 1'b1; bus_if.limit_val = 8'hFF; bus_if.mode = 2'b00;
    bus_if.step = 4'd1; bus_if.dir = 1'b1; bus_if.oe = 1'b0;
    cyc();
    bus_if.clr = 1'b0; bus_if.limit_we = 1'b0; bus_if.en = 1'b1;
    repeat (3) cyc();
    chk("oe0_qout", 32'(bus_if.q_out), 0);
    chk("oe0_qoe", 32'(bus_if.q_oe), 0);
    chk("oe0_cnt", 32'(bus_if.count), 3);
    bus_if.oe = 1'b1;
    #1;
    chk("oe1_qout", 32'(bus_if.q_out), 3);
    chk("oe1_qoe", 32'(bus_if.q_oe), 1);

    // Asynchronous reset while counting at 0x37, then wrap at the reset limit 0xFF.
    bus_if.en = 1'b0; bus_if.load = 1'b1; bus_if.load_val = 8'h36;
    bus_if.limit_we = 1'b1; bus_if.limit_val = 8'h40;
    cyc();
    bus_if.load = 1'b0; bus_if.limit_we = 1'b0; bus_if.en = 1'b1;
    cyc();
    chk("pre_rst_cnt", 32'(bus_if.count), 8'h37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cnt", 32'(bus_if.count), 0);
    chk("rst_tc", 32'(bus_if.tc), 0);
    chk("rst_halt", 32'(bus_if.halted), 0);
    model_reset();
    bus_if.en = 1'b0; bus_if.load = 1'b1; bus_if.load_val = 8'hFE;
    #2;
    rst_n = 1'b1;
    cyc();
    bus_if.load = 1'b0; bus_if.en = 1'b1;
    cyc();
    chk("rst_lim_ff", 32'(bus_if.count), 8'hFF);
    cyc();
    chk("rst_lim_wrap", 32'(bus_if.count), 0);
    chk("rst_lim_tc", 32'(bus_if.tc), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus_if.clr       = ($urandom_range(0, 15) == 0);
      bus_if.load      = ($urandom_range(0, 7) == 0);
      bus_if.limit_we  = ($urandom_range(0, 9) == 0);
      bus_if.limit_val = 8'($urandom_range(0, 255));
      bus_if.load_val  = 8'($urandom_range(0, 255));
      bus_if.en        = ($urandom_range(0, 3) != 0);
      bus_if.dir       = 1'($urandom_range(0, 1));
      bus_if.step      = 4'($urandom_range(0, 15));
      bus_if.mode      = 2'($urandom_range(0, 3));
      bus_if.oe        = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_counter_n.md
PROG_COUNTER_N -- requirements
Module: prog_counter_n

Interface
REQ-001 Parameter WIDTH, default 8: counter, load, limit and output width; legal range 2..32.
REQ-002 Parameter STEP_W, default 4: width of step input; SHALL be <= WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 en  in  1  count enable; one step per enabled cycle.
REQ-006 clr  in  1  synchronous clear of count and halted.
REQ-007 load  in  1  synchronous load of load_val into count.
REQ-008 load_val  in  WIDTH  value loaded when load=1.
REQ-009 limit_we  in  1  synchronous write of limit register.
REQ-010 limit_val  in  WIDTH  new limit value.
REQ-011 dir  in  1  1 = count up, 0 = count down.
REQ-012 step  in  STEP_W  unsigned increment/decrement magnitude.
REQ-013 mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-014 oe  in  1  output enable.
REQ-015 count  out  WIDTH  raw counter value, always driven.
REQ-016 q_out  out  WIDTH  count when oe=1, else all zeros; no tristate inside block.
REQ-017 q_oe  out  1  equals oe, for pad enable at top level.
REQ-018 tc  out  1  registered terminal-count flag.
REQ-019 halted  out  1  one-shot terminal reached; counting frozen.

Function
REQ-020 Priority per edge: clr > load > en; limit_we independent and applied on same edge as any of them.
REQ-021 clr=1: count <= 0, halted <= 0, tc <= 0.
REQ-022 load=1 (clr=0): count <= load_val, halted <= 0, tc <= 0; load_val above limit accepted unchanged.
REQ-023 Step executes only when en=1, clr=0, load=0, halted=0; otherwise count holds and tc <= 0.
REQ-024 Up crossing: (count + step) > limit, evaluated at WIDTH+1 bits, no intermediate overflow.
REQ-025 Down crossing: count < step.
REQ-026 No crossing: count <= count + step (up) or count - step (down).
REQ-027 Crossing, wrap mode: count <= 0 (up) or limit (down); modulo limit+1 sequence when step=1.
REQ-028 Crossing, saturate mode: count <= limit (up) or 0 (down).
REQ-029 Crossing, one-shot mode: as saturate, plus halted <= 1.
REQ-030 tc <= 1 on every executed step that is a crossing, else 0; tc therefore coincides with the post-crossing count.
REQ-031 Saturate held at boundary with en=1: each further step is a crossing; tc stays 1.
REQ-032 step=0: count holds; no crossing possible; tc <= 0.
REQ-033 limit_we while count > new limit: count unchanged; next up step is a crossing.
REQ-034 mode or dir change takes effect on the next executed step; no state flush.
REQ-035 halted cleared only by clr, load or reset; mode change does not clear it.
REQ-036 q_out, q_oe combinational from count and oe; oe never affects counting.

Reset
REQ-037 rst_n=0 immediately forces count=0, limit=all ones, tc=0, halted=0, independent of clk.
REQ-038 Deassertion: first counting edge is the first rising clk with rst_n=1; no state change before it.
REQ-039 Reset mid-operation discards any in-flight load, clr or limit write on that edge.

Verification (WIDTH=8, STEP_W=4)
REQ-040 Counting at 0x37, pull rst_n low between edges -> count=0x00, tc=0, halted=0 before next edge; limit reads back as 0xFF (observed by wrap at 0xFF).
REQ-041 Wrap, limit=9, step=1, up, en held 11 cycles from 0 -> count 1..9,0,1; tc=1 only in the cycle count=0.
REQ-042 Saturate, down, step=3, load 7 -> count 4,1,0,0; tc=0,0,1,1.
REQ-043 One-shot, up, limit=5, step=2, from 0 -> 2,4,5 with halted=1,tc=1; further en keeps 5, tc=0; load 0x01 -> count=1, halted=0.
REQ-044 Same edge clr=1, load=1, en=1 -> count=0; next edge load=1 (load_val=0x80), en=1 -> count=0x80.
REQ-045 oe=0 while counting up from 0 -> q_out=0x00, q_oe=0, count keeps incrementing; oe=1 -> q_out equals count same cycle.
